// File: rtl/la_matmul_sequencer_pkg.sv
// Shared types and constants for the 4x4 matmul sequencer.
// Holds FSM states, operand matrices and marker defaults.
package la_matmul_sequencer_pkg;

  typedef logic [15:0] data_t;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_MSTART,
    ST_COMPUTE,
    ST_SHOW,
    ST_MEND
  } state_t;

  localparam data_t MARK_START_DEF = 16'hAB40;
  localparam data_t MARK_END_DEF   = 16'hAB51;

  localparam data_t MAT_A [4][4] = '{
    '{16'd0, 16'd1, 16'd2, 16'd3},
    '{16'd0, 16'd1, 16'd2, 16'd3},
    '{16'd0, 16'd1, 16'd2, 16'd3},
    '{16'd0, 16'd1, 16'd2, 16'd3}
  };

  localparam data_t MAT_B [4][4] = '{
    '{16'd1,  16'd2,  16'd3,  16'd4},
    '{16'd5,  16'd6,  16'd7,  16'd8},
    '{16'd9,  16'd10, 16'd11, 16'd12},
    '{16'd13, 16'd14, 16'd15, 16'd16}
  };

endpackage

// File: rtl/la_matmul_sequencer_if.sv
// Pad-side bundle of the sequencer: GPIO out/oeb plus status.
// master drives the pads, slave observes them.
interface la_matmul_sequencer_if;
  logic [37:0] mprj_io_out;
  logic [37:0] mprj_io_oeb;
  logic        busy;
  logic        done;

  modport master (
    output mprj_io_out,
    output mprj_io_oeb,
    output busy,
    output done
  );

  modport slave (
    input mprj_io_out,
    input mprj_io_oeb,
    input busy,
    input done
  );
endinterface

// File: rtl/la_mac16.sv
// 16-bit multiply-accumulate, wraps mod 2^16.
// clear with enable loads a*b, starting a new dot product.
module la_mac16
  import la_matmul_sequencer_pkg::*;
(
  input  logic  clock,
  input  logic  resetb,
  input  data_t a,
  input  data_t b,
  input  logic  clear,
  input  logic  enable,
  output data_t acc
);

  data_t prod;

  assign prod = a * b;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      acc <= '0;
    end else if (enable) begin
      acc <= clear ? prod : acc + prod;
    end else if (clear) begin
      acc <= '0;
    end
  end

endmodule

// File: rtl/la_matmul_sequencer.sv
// Boot delay, marker, C = A x B on one MAC, shows C[0][*], end marker.
// checkbits is registered so pad values never glitch.
module la_matmul_sequencer
  import la_matmul_sequencer_pkg::*;
#(
  parameter int    BOOT_CYCLES = 64,
  parameter int    HOLD_CYCLES = 16,
  parameter data_t MARK_START  = MARK_START_DEF,
  parameter data_t MARK_END    = MARK_END_DEF
) (
  input  logic clock,
  input  logic resetb,
  la_matmul_sequencer_if.master io
);

  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t          state_q, state_d;
  logic [BW-1:0]   boot_q, boot_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [5:0]      mac_q, mac_d;
  logic [1:0]      sidx_q, sidx_d;
  data_t           cb_q, cb_d;
  data_t           res_q [16];
  logic            wr_q;
  logic [3:0]      wr_idx_q;
  data_t           acc;
  data_t           op_a, op_b;
  logic            mac_en, mac_clr;

  // mac_q = {row, col, k}: row-major over C, inner k
  assign mac_en  = state_q == ST_COMPUTE;
  assign mac_clr = mac_q[1:0] == 2'd0;
  assign op_a    = MAT_A[mac_q[5:4]][mac_q[1:0]];
  assign op_b    = MAT_B[mac_q[1:0]][mac_q[3:2]];

  la_mac16 u_mac (
    .clock  (clock),
    .resetb (resetb),
    .a      (op_a),
    .b      (op_b),
    .clear  (mac_clr),
    .enable (mac_en),
    .acc    (acc)
  );

  // acc is complete one cycle after the k=3 MAC
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_q     <= 1'b0;
      wr_idx_q <= '0;
      for (int i = 0; i < 16; i++) res_q[i] <= '0;
    end else begin
      wr_q     <= mac_en && (mac_q[1:0] == 2'd3);
      wr_idx_q <= mac_q[5:2];
      if (wr_q) res_q[wr_idx_q] <= acc;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_BOOT;
      boot_q  <= '0;
      hold_q  <= '0;
      mac_q   <= '0;
      sidx_q  <= '0;
      cb_q    <= '0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      hold_q  <= hold_d;
      mac_q   <= mac_d;
      sidx_q  <= sidx_d;
      cb_q    <= cb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    boot_d  = boot_q;
    hold_d  = hold_q;
    mac_d   = mac_q;
    sidx_d  = sidx_q;
    cb_d    = cb_q;
    unique case (state_q)
      ST_BOOT: begin
        if (boot_q == BOOT_LAST) begin
          state_d = ST_MSTART;
          boot_d  = '0;
          cb_d    = MARK_START;
        end else begin
          boot_d = boot_q + 1'b1;
        end
      end
      ST_MSTART: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_COMPUTE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_COMPUTE: begin
        mac_d = mac_q + 6'd1;
        if (mac_q == 6'd63) begin
          state_d = ST_SHOW;
          sidx_d  = '0;
          cb_d    = res_q[0];
        end
      end
      ST_SHOW: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (sidx_q == 2'd3) begin
            state_d = ST_MEND;
            cb_d    = MARK_END;
          end else begin
            sidx_d = sidx_q + 2'd1;
            cb_d   = res_q[4'(sidx_q) + 4'd1];
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_MEND: begin
        cb_d = MARK_END;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign io.mprj_io_out = {6'b0, cb_q, 9'b0, 1'b1, 6'b0};
  assign io.mprj_io_oeb = {6'h3f, 16'h0, 9'h1ff, 1'b0, 6'h3f};
  assign io.busy = (state_q == ST_MSTART) || (state_q == ST_COMPUTE)
                || (state_q == ST_SHOW);
  assign io.done = state_q == ST_MEND;

endmodule

// File: tb/tb_la_matmul_sequencer.sv
// Directed bench: dut1 BOOT=8/HOLD=4, dut2 BOOT=8/HOLD=1.
// Vector table keyed by cycles after reset release.
module tb_la_matmul_sequencer;
  import la_matmul_sequencer_pkg::*;

  typedef struct {
    int          dut;
    int          cyc;
    logic [15:0] cb;
    logic        busy;
    logic        done;
  } vec_t;

  logic clock = 1'b0;
  logic rstb1, rstb2;
  logic log_en;
  int   errors = 0;
  int   checks = 0;
  int   n;
  data_t q1 [$];
  data_t q2 [$];
  data_t last1, last2;

  la_matmul_sequencer_if bus1 ();
  la_matmul_sequencer_if bus2 ();

  la_matmul_sequencer #(.BOOT_CYCLES(8), .HOLD_CYCLES(4)) dut1 (
    .clock  (clock),
    .resetb (rstb1),
    .io     (bus1)
  );

  la_matmul_sequencer #(.BOOT_CYCLES(8), .HOLD_CYCLES(1)) dut2 (
    .clock  (clock),
    .resetb (rstb2),
    .io     (bus2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // pad bits outside checkbits are fixed at all times
  always @(negedge clock) begin
    chk("pad_out1", bus1.mprj_io_out & ~38'h00_FFFF_0000, 38'h40);
    chk("pad_oeb1", bus1.mprj_io_oeb, 38'h3F_0000_FFBF);
    chk("pad_out2", bus2.mprj_io_out & ~38'h00_FFFF_0000, 38'h40);
    chk("pad_oeb2", bus2.mprj_io_oeb, 38'h3F_0000_FFBF);
  end

  always @(negedge clock) begin
    if (log_en) begin
      if (bus1.mprj_io_out[31:16] != last1) begin
        last1 = bus1.mprj_io_out[31:16];
        q1.push_back(last1);
      end
      if (bus2.mprj_io_out[31:16] != last2) begin
        last2 = bus2.mprj_io_out[31:16];
        q2.push_back(last2);
      end
    end
  end

  initial begin
    vec_t  vt [$];
    data_t exp_seq [6];
    data_t exp_row [4];
    logic  hit;

    exp_seq = '{16'hAB40, 16'h003E, 16'h0044,
                16'h004A, 16'h0050, 16'hAB51};
    exp_row = '{16'd62, 16'd68, 16'd74, 16'd80};

    vt.push_back('{1, 0,   16'h0000, 1'b0, 1'b0});
    vt.push_back('{2, 0,   16'h0000, 1'b0, 1'b0});
    vt.push_back('{1, 7,   16'h0000, 1'b0, 1'b0});
    vt.push_back('{2, 7,   16'h0000, 1'b0, 1'b0});
    vt.push_back('{1, 8,   16'hAB40, 1'b1, 1'b0});
    vt.push_back('{2, 8,   16'hAB40, 1'b1, 1'b0});
    vt.push_back('{1, 12,  16'hAB40, 1'b1, 1'b0});
    vt.push_back('{2, 72,  16'hAB40, 1'b1, 1'b0});
    vt.push_back('{2, 73,  16'h003E, 1'b1, 1'b0});
    vt.push_back('{2, 74,  16'h0044, 1'b1, 1'b0});
    vt.push_back('{2, 75,  16'h004A, 1'b1, 1'b0});
    vt.push_back('{1, 75,  16'hAB40, 1'b1, 1'b0});
    vt.push_back('{2, 76,  16'h0050, 1'b1, 1'b0});
    vt.push_back('{1, 76,  16'h003E, 1'b1, 1'b0});
    vt.push_back('{2, 77,  16'hAB51, 1'b0, 1'b1});
    vt.push_back('{1, 79,  16'h003E, 1'b1, 1'b0});
    vt.push_back('{1, 80,  16'h0044, 1'b1, 1'b0});
    vt.push_back('{1, 84,  16'h004A, 1'b1, 1'b0});
    vt.push_back('{1, 88,  16'h0050, 1'b1, 1'b0});
    vt.push_back('{1, 91,  16'h0050, 1'b1, 1'b0});
    vt.push_back('{1, 92,  16'hAB51, 1'b0, 1'b1});
    vt.push_back('{1, 200, 16'hAB51, 1'b0, 1'b1});

    rstb1 = 1'b0;
    rstb2 = 1'b0;
    log_en = 1'b0;
    last1 = '0;
    last2 = '0;
    repeat (3) @(posedge clock);
    #2;
    chk("rst_cb", bus1.mprj_io_out[31:16], 16'h0);
    chk("rst_busy", bus1.busy, 1'b0);
    chk("rst_done", bus1.done, 1'b0);
    chk("rst_res", dut1.res_q[0], 16'h0);

    @(negedge clock);
    rstb1 = 1'b1;
    rstb2 = 1'b1;
    log_en = 1'b1;
    n = 0;
    #1;
    foreach (vt[i]) begin
      while (n < vt[i].cyc) begin
        @(posedge clock);
        n++;
        #2;
      end
      if (vt[i].dut == 1) begin
        chk($sformatf("vec%0d_cb", i), bus1.mprj_io_out[31:16], vt[i].cb);
        chk($sformatf("vec%0d_busy", i), bus1.busy, vt[i].busy);
        chk($sformatf("vec%0d_done", i), bus1.done, vt[i].done);
      end else begin
        chk($sformatf("vec%0d_cb", i), bus2.mprj_io_out[31:16], vt[i].cb);
        chk($sformatf("vec%0d_busy", i), bus2.busy, vt[i].busy);
        chk($sformatf("vec%0d_done", i), bus2.done, vt[i].done);
      end
    end

    for (int c = 0; c < 1000; c++) begin
      @(posedge clock);
      #2;
      chk("hold_end_cb", bus1.mprj_io_out[31:16], 16'hAB51);
      chk("hold_end_done", bus1.done, 1'b1);
      chk("hold_end_cb2", bus2.mprj_io_out[31:16], 16'hAB51);
    end

    log_en = 1'b0;
    chk("seq1_len", q1.size(), 6);
    chk("seq2_len", q2.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < q1.size()) chk($sformatf("seq1_%0d", i), q1[i], exp_seq[i]);
      if (i < q2.size()) chk($sformatf("seq2_%0d", i), q2[i], exp_seq[i]);
    end
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("res_r%0d_c%0d", r, j), dut1.res_q[4*r+j], exp_row[j]);

    // restart, then abort with reset while 0x0044 is showing
    @(negedge clock);
    rstb1 = 1'b0;
    @(negedge clock);
    rstb1 = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(posedge clock);
      #2;
      if (bus1.mprj_io_out[31:16] == 16'h0044) hit = 1'b1;
    end
    chk("reach_0044", hit, 1'b1);
    @(posedge clock);
    #3;
    rstb1 = 1'b0;
    #1;
    chk("abort_cb", bus1.mprj_io_out[31:16], 16'h0);
    chk("abort_busy", bus1.busy, 1'b0);
    chk("abort_done", bus1.done, 1'b0);
    chk("abort_tx", bus1.mprj_io_out[6], 1'b1);
    chk("abort_res", dut1.res_q[1], 16'h0);
    repeat (2) @(negedge clock);
    rstb1 = 1'b1;
    n = 0;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge clock);
      n++;
      #2;
      if (bus1.mprj_io_out[31:16] != 16'h0) hit = 1'b1;
    end
    chk("restart_seen", hit, 1'b1);
    chk("restart_cyc", n, 8);
    chk("restart_cb", bus1.mprj_io_out[31:16], 16'hAB40);
    chk("restart_busy", bus1.busy, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
